// File: rtl/fa_pkg.sv
// Shared definitions for the fa_nbit adder: width limit and a behavioural
// reference sum used by checkers.
package fa_pkg;

  localparam int unsigned FA_MAX_N = 64;

  // Reference (n+1)-bit result of a + b + cin, operands taken as n-bit unsigned.
  // The result sits in the low n+1 bits of the return value; upper bits are zero.
  function automatic logic [FA_MAX_N:0] fa_ref_add(
    input logic [FA_MAX_N-1:0] a,
    input logic [FA_MAX_N-1:0] b,
    input logic                cin,
    input int unsigned         n
  );
    logic [FA_MAX_N:0] op_mask;
    logic [FA_MAX_N:0] res_mask;
    logic [FA_MAX_N:0] total;
    op_mask  = (({{FA_MAX_N{1'b0}}, 1'b1}) << n) - 1'b1;
    res_mask = (({{FA_MAX_N{1'b0}}, 1'b1}) << (n + 1)) - 1'b1;
    // For n = FA_MAX_N the second shift runs off the top, giving an all-ones mask.
    total = ({1'b0, a} & op_mask) + ({1'b0, b} & op_mask) + {{FA_MAX_N{1'b0}}, cin};
    return total & res_mask;
  endfunction

endpackage

// File: rtl/fa_bit.sv
// Single-bit full adder cell, the building block of the ripple chain.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/fa_nbit.sv
// N-bit ripple-carry adder with a one-cycle registered output stage and a
// valid bit travelling alongside the data.
// Optional feature: define FA_NBIT_OVF_EN to add the registered signed
// overflow output ovf.
module fa_nbit
  import fa_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         zero
`ifdef FA_NBIT_OVF_EN
  ,
  output logic         ovf
`endif
);

  // Reject illegal widths at elaboration time.
  if (N < 1 || N > int'(FA_MAX_N)) begin : g_bad_n
    $error("fa_nbit: N=%0d outside legal range 1..%0d", N, FA_MAX_N);
  end

  logic [N:0]   c;
  logic [N-1:0] s_d;
  logic         cout_d;
  logic         zero_d;

  logic         out_valid_q;
  logic [N-1:0] sum_q;
  logic         cout_q;
  logic         zero_q;

  assign c[0] = cin;

  // Ripple chain: carry out of each cell feeds the carry in of the next.
  for (genvar gi = 0; gi < N; gi++) begin : g_chain
    fa_bit u_bit (
      .a  (a[gi]),
      .b  (b[gi]),
      .ci (c[gi]),
      .s  (s_d[gi]),
      .co (c[gi+1])
    );
  end

  assign cout_d = c[N];
  assign zero_d = (s_d == '0);

  // Valid flag: plain registered copy of in_valid, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
    end
  end

  // Data registers: load on in_valid, otherwise hold the last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      zero_q <= 1'b1;
    end else if (in_valid) begin
      sum_q  <= s_d;
      cout_q <= cout_d;
      zero_q <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign zero      = zero_q;

`ifdef FA_NBIT_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  // With N = 1 the carry into the sign bit is cin itself.
  assign ovf_d = c[N] ^ c[N-1];

  // Overflow register shares the data enable and resets to no-overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (in_valid) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_fa_nbit.sv
// Directed and swept checks of fa_nbit (main instance N=8, sweep at N=1,4,16,64).
`timescale 1ns/1ps
module tb_fa_nbit;
  import fa_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic in_valid;

  // Main N=8 instance
  logic [7:0] a8, b8, sum8;
  logic       cin8, ov8_valid, cout8, zero8;
`ifdef FA_NBIT_OVF_EN
  logic       ovf8;
`endif

  fa_nbit #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a(a8), .b(b8), .cin(cin8),
    .out_valid(ov8_valid), .sum(sum8), .cout(cout8), .zero(zero8)
`ifdef FA_NBIT_OVF_EN
    , .ovf(ovf8)
`endif
  );

  // Sweep instances
  logic [0:0]  a1, b1, sum1;
  logic [3:0]  a4, b4, sum4;
  logic [15:0] a16, b16, sum16;
  logic [63:0] a64, b64, sum64;
  logic        cin1, cin4, cin16, cin64;
  logic        v1, v4, v16, v64;
  logic        co1, co4, co16, co64;
  logic        z1, z4, z16, z64;
`ifdef FA_NBIT_OVF_EN
  logic        ovf1, ovf4, ovf16, ovf64;
`endif

  fa_nbit #(.N(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a1), .b(b1), .cin(cin1),
    .out_valid(v1), .sum(sum1), .cout(co1), .zero(z1)
`ifdef FA_NBIT_OVF_EN
    , .ovf(ovf1)
`endif
  );
  fa_nbit #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a4), .b(b4), .cin(cin4),
    .out_valid(v4), .sum(sum4), .cout(co4), .zero(z4)
`ifdef FA_NBIT_OVF_EN
    , .ovf(ovf4)
`endif
  );
  fa_nbit #(.N(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a16), .b(b16), .cin(cin16),
    .out_valid(v16), .sum(sum16), .cout(co16), .zero(z16)
`ifdef FA_NBIT_OVF_EN
    , .ovf(ovf16)
`endif
  );
  fa_nbit #(.N(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a64), .b(b64), .cin(cin64),
    .out_valid(v64), .sum(sum64), .cout(co64), .zero(z64)
`ifdef FA_NBIT_OVF_EN
    , .ovf(ovf64)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then sample away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive an N=8 operation, clock it, and print the transaction.
  task automatic op8(input logic v, input logic r, input logic [7:0] av, input logic [7:0] bv, input logic c);
    in_valid = v; rst = r; a8 = av; b8 = bv; cin8 = c;
    tick();
    $display("t=%0t rst=%0b v=%0b a=%02h b=%02h cin=%0b -> ov=%0b sum=%02h cout=%0b zero=%0b",
             $time, r, v, av, bv, c, ov8_valid, sum8, cout8, zero8);
  endtask

  task automatic exp8(input string tag, input logic ev, input logic [7:0] es, input logic ec,
                      input logic ez, input logic eo);
    check({tag, ".out_valid"}, 65'(ov8_valid), 65'(ev));
    check({tag, ".sum"},       65'(sum8),      65'(es));
    check({tag, ".cout"},      65'(cout8),     65'(ec));
    check({tag, ".zero"},      65'(zero8),     65'(ez));
`ifdef FA_NBIT_OVF_EN
    check({tag, ".ovf"},       65'(ovf8),      65'(eo));
`else
    if (eo === 1'bx) $display("unexpected X in expectation table");
`endif
  endtask

  logic [64:0] r1, r4, r16, r64;

  initial begin
    rst = 1'b1; in_valid = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0;
    a1 = '0; b1 = '0; cin1 = 1'b0;
    a4 = '0; b4 = '0; cin4 = 1'b0;
    a16 = '0; b16 = '0; cin16 = 1'b0;
    a64 = '0; b64 = '0; cin64 = 1'b0;

    // Reset held two cycles with valid random operands presented.
    for (int i = 0; i < 2; i++) begin
      op8(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
      exp8("reset", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end

    // Basic add and carry/wrap cases
    op8(1'b1, 1'b0, 8'hAA, 8'hF0, 1'b0); exp8("add_aa_f0", 1'b1, 8'h9A, 1'b1, 1'b0, 1'b0);
    op8(1'b1, 1'b0, 8'hFF, 8'h00, 1'b1); exp8("wrap_ff_00_c", 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    op8(1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1); exp8("ff_ff_c", 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);

    // Signed overflow cases (sum/cout checked in every build)
    op8(1'b1, 1'b0, 8'h7F, 8'h01, 1'b0); exp8("ovf_7f_01", 1'b1, 8'h80, 1'b0, 1'b0, 1'b1);
    op8(1'b1, 1'b0, 8'h80, 8'h80, 1'b0); exp8("ovf_80_80", 1'b1, 8'h00, 1'b1, 1'b1, 1'b1);
    op8(1'b1, 1'b0, 8'h10, 8'h20, 1'b0); exp8("no_ovf_10_20", 1'b1, 8'h30, 1'b0, 1'b0, 1'b0);

    // Hold while in_valid is low, with changing operands on the inputs
    op8(1'b1, 1'b0, 8'h01, 8'h02, 1'b0); exp8("hold_load", 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    op8(1'b0, 1'b0, 8'h55, 8'h66, 1'b0); exp8("hold1", 1'b0, 8'h03, 1'b0, 1'b0, 1'b0);
    op8(1'b0, 1'b0, 8'hFF, 8'h01, 1'b1); exp8("hold2", 1'b0, 8'h03, 1'b0, 1'b0, 1'b0);
    op8(1'b0, 1'b0, 8'h80, 8'h80, 1'b0); exp8("hold3", 1'b0, 8'h03, 1'b0, 1'b0, 1'b0);

    // Mid-stream reset beats in_valid; 0x0A must never appear
    op8(1'b1, 1'b1, 8'h05, 8'h05, 1'b0); exp8("midrst", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    op8(1'b0, 1'b0, 8'h05, 8'h05, 1'b0); exp8("after_rst", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Random back-to-back sweep across widths
    for (int i = 0; i < 10000; i++) begin
      in_valid = 1'b1; rst = 1'b0;
      a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
      a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; cin64 = 1'($urandom);
      // Bias a few iterations toward all-ones operands to hit the full ripple.
      if (i % 97 == 0) begin
        a1 = '1; b1 = '1; a4 = '1; b4 = '1; a16 = '1; b16 = '1; a64 = '1; b64 = '1;
      end
      r1  = fa_ref_add(64'(a1),  64'(b1),  cin1,  1);
      r4  = fa_ref_add(64'(a4),  64'(b4),  cin4,  4);
      r16 = fa_ref_add(64'(a16), 64'(b16), cin16, 16);
      r64 = fa_ref_add(a64, b64, cin64, 64);
      tick();
      if (i < 4)
        $display("t=%0t sweep#%0d n64 a=%016h b=%016h cin=%0b -> cout=%0b sum=%016h",
                 $time, i, a64, b64, cin64, co64, sum64);
      check("sweep_n1",  65'({co1, sum1}),   r1);
      check("sweep_n4",  65'({co4, sum4}),   r4);
      check("sweep_n16", 65'({co16, sum16}), r16);
      check("sweep_n64", {co64, sum64},      r64);
      check("sweep_valid", 65'({v1, v4, v16, v64}), 65'(4'hF));
      check("sweep_zero64", 65'(z64), 65'(r64[63:0] == 64'd0));
`ifdef FA_NBIT_OVF_EN
      // Signed overflow: operands of equal sign producing a result of the other sign
      // (cin folded in by the reference sum).
      check("sweep_ovf16", 65'(ovf16),
            65'((a16[15] == b16[15]) ? (r16[15] != a16[15]) : 1'b0));
      check("sweep_ovf1", 65'(ovf1), 65'((a1[0] == b1[0]) ? (r1[0] != a1[0]) : 1'b0));
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fa_nbit.md
Name: fa_nbit

Overview:
- Parameterised N-bit binary adder: computes a + b + cin and produces an N-bit sum and a carry-out.
- Built as a ripple chain of single-bit full-adder cells.
- Results are captured in an output register stage, so the block sits as a one-cycle arithmetic stage inside clocked datapaths.
- A valid bit travels alongside the data.

Parameters:
- N, 8, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands on a/b/cin are valid this cycle.
- a  input  N  operand A, unsigned (also two's-complement for the overflow flag).
- b  input  N  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  sum/cout/zero hold a valid result.
- sum  output  N  registered low N bits of a + b + cin.
- cout  output  1  registered carry out of bit N-1.
- zero  output  1  registered; 1 when the registered sum is all zeros.

Behaviour:
- Combinational core:
  - c[0] = cin.
  - For each bit i: s[i] = a[i] ^ b[i] ^ c[i], and c[i+1] = a[i]&b[i] | a[i]&c[i] | b[i]&c[i].
  - The raw carry-out is c[N].
  - The result must equal the (N+1)-bit value a + b + cin, i.e. {cout, sum}.
- Latency: exactly 1 clock.
  - Operands sampled at edge k appear on sum/cout/zero/out_valid after edge k.
  - Throughput is one operation per cycle.
  - No backpressure and no stall input.
- out_valid is a registered copy of in_valid.
- Data registers (sum, cout, zero) load only when in_valid = 1. When in_valid = 0 they hold their previous values, while out_valid drops to 0.
- Reset (rst = 1 at a rising edge): sum = 0, cout = 0, zero = 1, out_valid = 0.
  - Reset has priority over in_valid.
  - Asserting rst mid-stream discards the operation sampled on that edge.
  - The first valid result after reset needs in_valid high on an edge with rst = 0.
- Wrap-around: a sum exceeding 2^N - 1 wraps modulo 2^N, with cout = 1.
- cin = 1 with a = b = all-ones gives sum = all-ones, cout = 1.
- No X propagation: every output has a defined value from reset onward.
- Elaboration must fail (generate-time error) if N < 1.

Optional Feature:
- Macro FA_NBIT_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit, registered).
  - ovf = c[N] ^ c[N-1] (two's-complement signed overflow).
  - ovf loads under the same in_valid enable as sum.
  - ovf resets to 0.
  - For N = 1, ovf = c[1] ^ cin.
- When undefined: the ovf port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package fa_pkg holds:
  - the constant FA_MAX_N = 64;
  - a function fa_ref_add(a, b, cin, n) returning the (n+1)-bit reference sum, for use by checkers.
- One natural sub-module: fa_bit, a single-bit full adder (inputs a, b, ci; outputs s, co). It is instantiated N times in a generate loop.
- fa_nbit holds the chain, the output registers and the optional overflow logic.

Test Plan:
- Reset: hold rst for 2 cycles with in_valid = 1 and random operands -> sum = 0x00, cout = 0, zero = 1, out_valid = 0 throughout.
- Basic add, N = 8: a = 0xAA, b = 0xF0, cin = 0, in_valid = 1 -> next cycle sum = 0x9A, cout = 1, zero = 0, out_valid = 1.
- Carry ripple and wrap: a = 0xFF, b = 0x00, cin = 1 -> sum = 0x00, cout = 1, zero = 1. Then a = b = 0xFF, cin = 1 -> sum = 0xFF, cout = 1.
- Signed overflow (FA_NBIT_OVF_EN defined): a = 0x7F, b = 0x01, cin = 0 -> sum = 0x80, cout = 0, ovf = 1. Then a = 0x80, b = 0x80 -> sum = 0x00, cout = 1, ovf = 1. Then a = 0x10, b = 0x20 -> ovf = 0.
- Hold and mid-stream reset:
  - Issue 0x01 + 0x02, then drop in_valid for 3 cycles -> sum stays 0x03, out_valid = 0.
  - Then assert rst together with in_valid (0x05 + 0x05) -> outputs return to reset values; 0x0A never appears.
- Parameter sweep at N = 1, 4, 16, 64: 10k random back-to-back operands -> each registered {cout, sum} equals fa_ref_add one cycle later.
